// File: rtl/vga_pkg.sv
// ============================================================================
// Module      : vga_pkg
// Description : Shared VGA pipeline definitions: default pixel width, timing
//               counter width, default colour key and background colour, and
//               the packed timing-bundle type carried between stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int          RGB_W_DEF = 12;
    localparam int          CNT_W     = 11;
    localparam logic [11:0] KEY_DEF   = 12'hF0F;
    localparam logic [11:0] BG_DEF    = 12'h000;

    // Timing strobes and counters travel together through every stage
    typedef struct packed {
        logic [CNT_W-1:0] hcount;
        logic [CNT_W-1:0] vcount;
        logic             hsync;
        logic             vsync;
        logic             hblnk;
        logic             vblnk;
    } timing_t;

    localparam int TIMING_W = $bits(timing_t);

endpackage

`default_nettype wire

// File: rtl/vga_delay_line.sv
// ============================================================================
// Module      : vga_delay_line
// Description : Fixed-depth register pipeline with asynchronous clear. Used
//               to align timing and pixel data through the mixer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            if (k == 0) begin : g_first
                // First stage captures the raw input
                always_ff @(posedge pclk or posedge rst) begin
                    if (rst) stage_q[0] <= '0;
                    else     stage_q[0] <= d_i;
                end
            end else begin : g_next
                // Later stages shift the previous stage along
                always_ff @(posedge pclk or posedge rst) begin
                    if (rst) stage_q[k] <= '0;
                    else     stage_q[k] <= stage_q[k-1];
                end
            end
        end
    endgenerate

    assign q_o = stage_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/vga_layer_mixer.sv
// ============================================================================
// Module      : vga_layer_mixer
// Description : Composites LAYERS colour-keyed RGB layers (highest enabled,
//               non-transparent layer wins), blanks the result during
//               h/v blanking, and delays pixel and timing by DELAY cycles.
//               The layer-enable mask is only updated at a vsync start so it
//               never changes mid-frame; a frame counter tracks vsync starts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_layer_mixer
    import vga_pkg::*;
#(
    parameter int                 LAYERS   = 3,
    parameter int                 RGB_W    = RGB_W_DEF,
    parameter int                 DELAY    = 2,
    parameter logic [RGB_W-1:0]   KEY      = RGB_W'(KEY_DEF),
    parameter logic [RGB_W-1:0]   BG_COLOR = RGB_W'(BG_DEF),
    parameter logic [LAYERS-1:0]  EN_RST   = '1
) (
    input  logic                      pclk,
    input  logic                      rst,
    input  logic [CNT_W-1:0]          hcount_in,
    input  logic [CNT_W-1:0]          vcount_in,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic                      hblnk_in,
    input  logic                      vblnk_in,
    input  logic [LAYERS*RGB_W-1:0]   rgb_in,
    input  logic [LAYERS-1:0]         layer_en_in,
    input  logic [LAYERS-1:0]         key_en,
    output logic [CNT_W-1:0]          hcount_out,
    output logic [CNT_W-1:0]          vcount_out,
    output logic                      hsync_out,
    output logic                      vsync_out,
    output logic                      hblnk_out,
    output logic                      vblnk_out,
    output logic [RGB_W-1:0]          rgb_out,
    output logic [LAYERS-1:0]         layer_en_active,
    output logic [15:0]               frame_cnt
);

    localparam int LINE_W = TIMING_W + RGB_W;

    logic                 vsync_prev_q;
    logic                 vsync_seen_low_q;
    logic                 vsync_start;
    logic [LAYERS-1:0]    layer_en_q;
    logic [LAYERS-1:0]    layer_en_d;
    logic [15:0]          frame_cnt_q;
    logic [15:0]          frame_cnt_d;
    logic [RGB_W-1:0]     pix_sel;
    logic [RGB_W-1:0]     pix_d;
    timing_t              tim_in;
    timing_t              tim_out;
    logic [LINE_W-1:0]    line_in;
    logic [LINE_W-1:0]    line_out;

    // A vsync held high through reset release must be seen low before
    // any rising edge counts, hence the seen-low qualifier.
    assign vsync_start = vsync_in & ~vsync_prev_q & vsync_seen_low_q;

    // Frame counter and mask advance only at a vsync start
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        layer_en_d  = layer_en_q;
        if (vsync_start) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            layer_en_d  = layer_en_in;
        end
    end

    // Vsync edge tracking, frame counter and active mask registers
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vsync_prev_q     <= 1'b0;
            vsync_seen_low_q <= 1'b0;
            frame_cnt_q      <= '0;
            layer_en_q       <= EN_RST;
        end else begin
            vsync_prev_q     <= vsync_in;
            vsync_seen_low_q <= vsync_seen_low_q | ~vsync_in;
            frame_cnt_q      <= frame_cnt_d;
            layer_en_q       <= layer_en_d;
        end
    end

    // Compositing on the input cycle, using the mask in force right now;
    // ascending scan lets the highest qualifying layer overwrite lower ones.
    always_comb begin
        pix_sel = BG_COLOR;
        for (int i = 0; i < LAYERS; i++) begin
            if (layer_en_q[i] &&
                (i == 0 || !key_en[i] || rgb_in[i*RGB_W +: RGB_W] != KEY)) begin
                pix_sel = rgb_in[i*RGB_W +: RGB_W];
            end
        end
        pix_d = (hblnk_in || vblnk_in) ? '0 : pix_sel;
    end

    assign tim_in.hcount = hcount_in;
    assign tim_in.vcount = vcount_in;
    assign tim_in.hsync  = hsync_in;
    assign tim_in.vsync  = vsync_in;
    assign tim_in.hblnk  = hblnk_in;
    assign tim_in.vblnk  = vblnk_in;
    assign line_in       = {tim_in, pix_d};

    // Timing and finished pixel share one pipeline so they stay aligned
    vga_delay_line #(
        .WIDTH (LINE_W),
        .DEPTH (DELAY)
    ) u_delay (
        .pclk (pclk),
        .rst  (rst),
        .d_i  (line_in),
        .q_o  (line_out)
    );

    assign tim_out         = line_out[LINE_W-1:RGB_W];
    assign rgb_out         = line_out[RGB_W-1:0];
    assign hcount_out      = tim_out.hcount;
    assign vcount_out      = tim_out.vcount;
    assign hsync_out       = tim_out.hsync;
    assign vsync_out       = tim_out.vsync;
    assign hblnk_out       = tim_out.hblnk;
    assign vblnk_out       = tim_out.vblnk;
    assign layer_en_active = layer_en_q;
    assign frame_cnt       = frame_cnt_q;

endmodule

`default_nettype wire
